// File: rtl/crypt_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : crypt_result_reader
//  Description : Captures a WIDTH-bit result word on a start strobe and
//                streams it out LSB chunk first as CHUNK-bit beats over a
//                four-phase valid/ack handshake. Reports completion with a
//                one-cycle done pulse and flags starts that arrive while a
//                transfer is already in progress (sticky overrun).
//  Ports       : clk, rst (sync, active-high), ena (global freeze when 0),
//                start, abort, C_ex[WIDTH], ack_i  -> inputs
//                data_o[CHUNK], valid_o, last_o, busy_o, done_o, overrun_o
//                -> registered outputs
//  Revision    : 1.0  initial release
// ============================================================================
module crypt_result_reader #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] C_ex,
    input  logic             ack_i,
    output logic [CHUNK-1:0] data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam int c_BEATS = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BEATS - 1);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_PRESENT  = 2'd1;
    localparam logic [1:0] c_S_WAIT_LOW = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_shadow;
    logic [CHUNK-1:0]   r_data;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;

    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0]   w_shadow_nxt;
    logic               w_done_nxt;
    logic               w_overrun_nxt;
    logic               w_valid_nxt;
    logic               w_last_nxt;
    logic               w_busy_nxt;
    logic [CHUNK-1:0]   w_data_nxt;
    logic [CHUNK-1:0]   w_chunks [c_BEATS];

    // Chunk view of the next shadow value so the output data register can be
    // loaded with the beat that will be presented after this edge.
    for (genvar gi = 0; gi < c_BEATS; gi++) begin : g_chunk
        assign w_chunks[gi] = w_shadow_nxt[gi*CHUNK +: CHUNK];
    end

    // Next-state logic. Outputs are derived from the next state so that they
    // can be registered and still line up with the state they describe.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_shadow_nxt  = r_shadow;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;

        if (abort) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        w_shadow_nxt = C_ex;
                        w_idx_nxt    = '0;
                        w_state_nxt  = c_S_PRESENT;
                    end
                end
                c_S_PRESENT: begin
                    if (start) w_overrun_nxt = 1'b1;
                    if (ack_i) w_state_nxt = c_S_WAIT_LOW;
                end
                c_S_WAIT_LOW: begin
                    if (start) w_overrun_nxt = 1'b1;
                    if (!ack_i) begin
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt   = r_idx + c_IDX_W'(1);
                            w_state_nxt = c_S_PRESENT;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                end
            endcase
        end

        w_valid_nxt = (w_state_nxt == c_S_PRESENT);
        w_busy_nxt  = (w_state_nxt != c_S_IDLE);
        w_last_nxt  = w_valid_nxt && (w_idx_nxt == c_LAST_IDX);
        w_data_nxt  = w_valid_nxt ? w_chunks[w_idx_nxt] : '0;
    end

    // ena=0 holds every register, including a pending done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_shadow  <= w_shadow_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign last_o    = r_last;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_crypt_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crypt_result_reader
//  Description : Self-checking bench for crypt_result_reader (WIDTH=8,
//                CHUNK=4): directed vector table, hand-written corner-case
//                sequences and a randomized host against a transaction model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crypt_result_reader;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int c_BEATS = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             ena;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] C_ex;
    logic             ack_i;
    logic [CHUNK-1:0] data_o;
    logic             valid_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;
    logic             overrun_o;

    crypt_result_reader #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .abort     (abort),
        .C_ex      (C_ex),
        .ack_i     (ack_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [7:0] w;
        logic [3:0] d0;
        logic [3:0] d1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs are also
    // changed there so they are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host side of one complete prompt transfer, starting while beat0 is shown.
    task automatic run_beats(input logic [3:0] e0, input logic [3:0] e1, input string tag);
        for (int b = 0; b < 2; b++) begin
            chk({tag, " valid"}, 32'(valid_o), 32'd1);
            chk({tag, " data"},  32'(data_o), 32'(b == 0 ? e0 : e1));
            chk({tag, " last"},  32'(last_o), 32'(b == 1));
            ack_i = 1'b1;
            tick();
            chk({tag, " valid drop"}, 32'(valid_o), 32'd0);
            chk({tag, " data zero"},  32'(data_o), 32'd0);
            ack_i = 1'b0;
            tick();
            if (b == 1) begin
                chk({tag, " done"}, 32'(done_o), 32'd1);
                chk({tag, " busy end"}, 32'(busy_o), 32'd0);
            end else begin
                chk({tag, " done early"}, 32'(done_o), 32'd0);
            end
        end
        tick();
        chk({tag, " done width"}, 32'(done_o), 32'd0);
    endtask

    task automatic do_start(input logic [7:0] w);
        C_ex  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Randomized host against a transaction model: a word is a list of
    // nibbles, LSB first; overrun is a sticky flag set by any accepted start
    // that arrives while a transfer is outstanding.
    task automatic random_test(input int n_trans);
        logic       m_ovr;
        logic [7:0] w;
        logic [3:0] exp;
        int         k;
        m_ovr = 1'b0;
        for (int t = 0; t < n_trans; t++) begin
            w = 8'($urandom);
            do_start(w);
            C_ex = 8'($urandom);
            for (int b = 0; b < c_BEATS; b++) begin
                exp = 4'((w >> (b * CHUNK)) & 8'hF);
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) begin
                    chk("rnd present valid", 32'(valid_o), 32'd1);
                    chk("rnd present data", 32'(data_o), 32'(exp));
                    ena   = ($urandom_range(0, 2) != 0);
                    start = ($urandom_range(0, 7) == 0);
                    C_ex  = 8'($urandom);
                    if (ena && start) m_ovr = 1'b1;
                    tick();
                    start = 1'b0;
                    ena   = 1'b1;
                end
                chk("rnd data", 32'(data_o), 32'(exp));
                chk("rnd last", 32'(last_o), 32'(b == c_BEATS - 1));
                chk("rnd overrun", 32'(overrun_o), 32'(m_ovr));
                ack_i = 1'b1;
                k = $urandom_range(0, 2);
                ena = 1'b0;
                for (int i = 0; i < k; i++) begin
                    tick();
                    chk("rnd freeze hold", 32'(valid_o), 32'd1);
                end
                ena = 1'b1;
                tick();
                chk("rnd ack drop", 32'(valid_o), 32'd0);
                k = $urandom_range(0, 2);
                for (int i = 0; i < k; i++) begin
                    tick();
                    chk("rnd wait low", 32'(valid_o), 32'd0);
                    chk("rnd wait busy", 32'(busy_o), 32'd1);
                end
                ack_i = 1'b0;
                tick();
            end
            chk("rnd done", 32'(done_o), 32'd1);
            chk("rnd idle", 32'(busy_o), 32'd0);
            k = $urandom_range(0, 2);
            ena = 1'b0;
            for (int i = 0; i < k; i++) begin
                tick();
                chk("rnd done held", 32'(done_o), 32'd1);
            end
            ena = 1'b1;
            tick();
            chk("rnd done clear", 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{w: 8'hA5, d0: 4'h5, d1: 4'hA};
        vecs[1] = '{w: 8'h3C, d0: 4'hC, d1: 4'h3};
        vecs[2] = '{w: 8'h7E, d0: 4'hE, d1: 4'h7};
        vecs[3] = '{w: 8'h12, d0: 4'h2, d1: 4'h1};
        vecs[4] = '{w: 8'h00, d0: 4'h0, d1: 4'h0};
        vecs[5] = '{w: 8'hFF, d0: 4'hF, d1: 4'hF};

        rst = 1'b1; ena = 1'b1; start = 1'b0; abort = 1'b0; C_ex = '0; ack_i = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            ena = 1'($urandom); start = 1'($urandom); abort = 1'($urandom);
            ack_i = 1'($urandom); C_ex = 8'($urandom);
            tick();
            chk("reset outs", {26'd0, data_o, valid_o, last_o}, 32'd0);
            chk("reset flags", {29'd0, busy_o, done_o, overrun_o}, 32'd0);
        end
        rst = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack_i = ~ack_i;
            tick();
            chk("idle ack no activity", {29'd0, valid_o, busy_o, done_o}, 32'd0);
        end
        ack_i = 1'b0;

        // Vector table.
        foreach (vecs[v]) begin
            do_start(vecs[v].w);
            C_ex = ~vecs[v].w;
            run_beats(vecs[v].d0, vecs[v].d1, "vec");
            chk("vec overrun", 32'(overrun_o), 32'd0);
        end

        // Overrun and snapshot.
        do_start(8'hA5);
        C_ex = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr flag", 32'(overrun_o), 32'd1);
        run_beats(4'h5, 4'hA, "ovr");
        chk("ovr sticky", 32'(overrun_o), 32'd1);
        do_reset();
        chk("ovr cleared", 32'(overrun_o), 32'd0);

        // Freeze during beat0 with ack high.
        do_start(8'hA5);
        ack_i = 1'b1;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz valid", 32'(valid_o), 32'd1);
            chk("frz data", 32'(data_o), 32'h5);
        end
        ena = 1'b1;
        tick();
        chk("frz ack taken", 32'(valid_o), 32'd0);
        ack_i = 1'b0;
        tick();
        chk("frz beat1", {27'd0, valid_o, data_o}, 32'h1A);
        chk("frz last", 32'(last_o), 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        chk("frz done", 32'(done_o), 32'd1);
        tick();

        // Abort in WAIT_LOW after beat0.
        do_start(8'hA5);
        ack_i = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ack_i = 1'b0;
        chk("abort outs", {29'd0, valid_o, busy_o, done_o}, 32'd0);
        chk("abort last", 32'(last_o), 32'd0);
        tick();
        chk("abort no done", {30'd0, busy_o, done_o}, 32'd0);
        do_start(8'h7E);
        run_beats(4'hE, 4'h7, "post abort");

        // Back-to-back: start in the cycle done_o is high.
        do_start(8'hA5);
        ack_i = 1'b1; tick(); ack_i = 1'b0; tick();
        ack_i = 1'b1; tick(); ack_i = 1'b0; tick();
        chk("b2b done", 32'(done_o), 32'd1);
        do_start(8'h12);
        chk("b2b accepted", {27'd0, valid_o, data_o}, 32'h12);
        chk("b2b no overrun", 32'(overrun_o), 32'd0);
        run_beats(4'h2, 4'h1, "b2b");
        chk("b2b overrun end", 32'(overrun_o), 32'd0);

        random_test(40);

        // Reset mid-transfer.
        do_start(8'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid", {24'd0, data_o, valid_o, last_o, busy_o, done_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crypt_result_reader.md
# crypt_result_reader

Read-side counterpart of the ciphertext result register: on a start strobe it snapshots the WIDTH-bit result word and streams it out to the chip pins as CHUNK-bit pieces over a four-phase valid/ack handshake. It sits between the result register output and the external output bus, so a slow host can read RSA results through a narrow port. It reports completion and flags starts that arrive while a transfer is already in progress.

## Interface
- WIDTH, 8: result word width; must be a nonzero multiple of CHUNK.
- CHUNK, 4: bits presented per handshake beat.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  global enable; when 0, all state and outputs hold and inputs are ignored (rst still acts).
- start  input  1  one-cycle strobe: C_ex holds a new result to transmit.
- abort  input  1  synchronous abandon of the current transfer.
- C_ex  input  WIDTH  result word from the result register.
- ack_i  input  1  host acknowledge, synchronous to clk.
- data_o  output  CHUNK  current chunk; 0 whenever valid_o=0.
- valid_o  output  1  data_o is valid.
- last_o  output  1  the current chunk is the final one; qualified by valid_o.
- busy_o  output  1  a transfer is in progress.
- done_o  output  1  one-cycle pulse: the transfer has completed.
- overrun_o  output  1  sticky: a start arrived while busy.

## Operation
- N = WIDTH/CHUNK beats. A shadow register holds the word, and a beat index counts 0..N-1.
- States: IDLE, PRESENT, WAIT_LOW.
- IDLE: valid_o=0, busy_o=0. When start=1 and ena=1: shadow<=C_ex, index<=0, go to PRESENT.
- PRESENT: valid_o=1, busy_o=1, data_o=shadow[index*CHUNK +: CHUNK] (LSB chunk first), last_o=(index==N-1). When ack_i=1, go to WAIT_LOW.
- WAIT_LOW: valid_o=0, data_o=0, busy_o=1. When ack_i=0:
  - if index==N-1: go to IDLE and pulse done_o;
  - otherwise: index<=index+1 and go to PRESENT.
- If ack_i is already high on entry to PRESENT, it is accepted on the first cycle in PRESENT.
- start while not IDLE: ignored; the shadow is unchanged and overrun_o<=1. overrun_o clears only on rst.
- start in the same cycle that done_o is asserted: accepted, because the state is already IDLE.
- abort=1 (with ena=1) in any state: go to IDLE, valid_o=0, last_o=0, busy_o=0, and no done_o. abort has priority over start and ack_i in the same cycle.
- The shadow decouples the transfer from C_ex; changes on C_ex after capture have no effect.
- N=1 is legal: the first beat is also last.
- Priority: rst > ena=0 (freeze) > abort > normal operation.

## Timing
- All outputs are registered.
- Reset values: data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, overrun_o=0, state=IDLE, index=0, shadow=0.
- rst mid-transfer: all outputs are at reset values in the next cycle.
- start sampled at edge n: valid_o=1 and chunk 0 are present from edge n+1.
- ack_i sampled high at edge m: valid_o=0 from edge m+1.
- ack_i sampled low at edge k: the next chunk is presented from edge k+1. On the last beat, done_o=1 for exactly cycle k+1 and busy_o=0 from k+1.
- Minimum beat period is 2 cycles (ack toggling every cycle), so minimum transfer latency is 2N+1 cycles from start to done_o.
- ena=0 cycles stretch any phase by exactly their count. A done_o pulse pending at a freeze is held until ena returns.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> every output is 0; ack_i pulses cause no activity.
- Basic (WIDTH=8, CHUNK=4): C_ex=0xA5, start, host acks promptly -> beat0 data_o=5 with last_o=0; beat1 data_o=A with last_o=1; done_o is high for exactly 1 cycle after the final ack_i falls; busy_o=0 afterwards.
- Overrun and snapshot: after starting 0xA5, drive C_ex=0x3C and start again during beat0 -> stream is still 5,A; overrun_o=1 and stays 1 after done_o; only rst clears it.
- Freeze: during PRESENT of beat0, ena=0 for 3 cycles while ack_i=1 -> valid_o, data_o=5 and state hold. ack_i is taken only once ena=1, with the drop of valid_o delayed by 3 cycles.
- Abort: abort in WAIT_LOW after beat0 -> next cycle valid_o=0, busy_o=0, no done_o. A new start with C_ex=0x7E streams E then 7.
- Back-to-back: start with C_ex=0x12 asserted in the same cycle as done_o of a prior transfer -> accepted with no overrun; the stream is 2 then 1.
